// File: rtl/accum_requant_pack_pkg.sv
// Shared widths, saturation bounds and the packed output word type for the
// accumulator requantize/pack block.
package accum_requant_pack_pkg;

    localparam int DATAW        = 32;
    localparam int OUTW         = 8;
    localparam int LANES        = 8;
    localparam int SCALEW       = 16;
    localparam int SHIFTW       = 6;
    localparam int FIFO_DEPTH   = 8;
    localparam int AFULL_MARGIN = 4;

    // Signed data times unsigned scale needs one extra bit to stay exact.
    localparam int PRODW = DATAW + SCALEW + 1;
    localparam int WORDW = LANES * OUTW;
    localparam int QMIN  = -128;
    localparam int QMAX  = 127;

    typedef logic [WORDW-1:0]       word_t;
    typedef logic signed [OUTW-1:0] elem_t;

    function automatic elem_t saturate(input logic signed [PRODW-1:0] v);
        if (v > PRODW'(QMAX)) return elem_t'(QMAX);
        if (v < PRODW'(QMIN)) return elem_t'(QMIN);
        return v[OUTW-1:0];
    endfunction

endpackage

// File: rtl/accum_requant_pack_if.sv
// Accumulator-side input stream plus packed-word ready/valid output stream.
interface accum_requant_pack_if;
    import accum_requant_pack_pkg::*;

    logic                     i_valid;
    logic signed [DATAW-1:0]  i_data;
    logic                     i_last;
    logic [SCALEW-1:0]        i_scale;
    logic [SHIFTW-1:0]        i_shift;
    logic signed [OUTW-1:0]   i_zero_point;
    logic                     i_relu;
    logic                     o_almost_full;
    logic                     o_overflow;
    logic                     o_valid;
    word_t                    o_data;
    logic                     i_ready;

    modport master (
        output i_valid, i_data, i_last, i_scale, i_shift, i_zero_point, i_relu, i_ready,
        input  o_almost_full, o_overflow, o_valid, o_data
    );

    modport slave (
        input  i_valid, i_data, i_last, i_scale, i_shift, i_zero_point, i_relu, i_ready,
        output o_almost_full, o_overflow, o_valid, o_data
    );

endinterface

// File: rtl/accum_requant_pack_sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO with an explicit occupancy count.
module sync_fifo_fwft #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 64,
    localparam int PTRW = $clog2(DEPTH),
    localparam int CNTW = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CNTW-1:0]  count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTRW-1:0]  wr_ptr;
    logic [PTRW-1:0]  rd_ptr;
    logic             wr_en;

    assign full  = (count == CNTW'(DEPTH));
    assign empty = (count == '0);
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign wr_en = push && (!full || pop);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNTW'(wr_en) - CNTW'(pop);
        end
    end

    // NOTE: the storage array has no reset; count/empty gate its contents,
    // and leaving it unreset lets it map onto plain RAM.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= push_data;
    end

    assign pop_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/accum_requant_pack.sv
// Requantizes 32-bit accumulator results to int8 (scale, round-shift, ReLU,
// zero point, saturate), packs LANES of them per word and buffers the words.
module accum_requant_pack
    import accum_requant_pack_pkg::*;
#(
    parameter int FIFO_DEPTH_P   = FIFO_DEPTH,
    parameter int AFULL_MARGIN_P = AFULL_MARGIN
) (
    input logic                 clk,
    input logic                 rst,
    accum_requant_pack_if.slave bus
);

    localparam int LANEW = $clog2(LANES);
    localparam int CNTW  = $clog2(FIFO_DEPTH_P) + 1;
    localparam logic [CNTW-1:0] AF_LEVEL = CNTW'(FIFO_DEPTH_P - AFULL_MARGIN_P);

    // ---------------- S1: exact product, config captured with the element
    logic                    s1_valid, s1_last, s1_relu;
    logic signed [PRODW-1:0] s1_prod;
    logic [SHIFTW-1:0]       s1_shift;
    elem_t                   s1_zp;
    logic signed [PRODW-1:0] prod_c;

    assign prod_c = PRODW'(bus.i_data) * PRODW'($signed({1'b0, bus.i_scale}));

    always_ff @(posedge clk) begin
        if (rst) s1_valid <= 1'b0;
        else     s1_valid <= bus.i_valid;
        if (bus.i_valid) begin
            s1_prod  <= prod_c;
            s1_last  <= bus.i_last;
            s1_relu  <= bus.i_relu;
            s1_shift <= bus.i_shift;
            s1_zp    <= bus.i_zero_point;
        end
    end

    // ---------------- S2: round-half-up arithmetic shift
    logic                    s2_valid, s2_last, s2_relu;
    logic signed [PRODW-1:0] s2_r;
    elem_t                   s2_zp;
    logic signed [PRODW-1:0] rnd_c, sum_c, shr_c;

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        rnd_c = '0;
        if (s1_shift != '0) rnd_c = PRODW'(1) << (s1_shift - 1'b1);
        sum_c = s1_prod + rnd_c;
        shr_c = sum_c >>> s1_shift;
    end

    always_ff @(posedge clk) begin
        if (rst) s2_valid <= 1'b0;
        else     s2_valid <= s1_valid;
        if (s1_valid) begin
            s2_r    <= shr_c;
            s2_last <= s1_last;
            s2_relu <= s1_relu;
            s2_zp   <= s1_zp;
        end
    end

    // ---------------- S3: ReLU, zero point, saturation
    logic                    s3_valid, s3_last;
    elem_t                   s3_q;
    logic signed [PRODW-1:0] relu_c, zsum_c;

    always_comb begin
        relu_c = s2_r;
        if (s2_relu && s2_r[PRODW-1]) relu_c = '0;
        zsum_c = relu_c + PRODW'(s2_zp);
    end

    always_ff @(posedge clk) begin
        if (rst) s3_valid <= 1'b0;
        else     s3_valid <= s2_valid;
        if (s2_valid) begin
            s3_q    <= saturate(zsum_c);
            s3_last <= s2_last;
        end
    end

    // ---------------- Packer: lanes above lane_cnt are always zero in asm_q
    logic [LANEW-1:0] lane_cnt;
    word_t            asm_q;
    word_t            word_c;
    logic             done_c;

    always_comb begin
        word_c = asm_q;
        word_c[lane_cnt*OUTW +: OUTW] = s3_q;
        done_c = s3_valid && (s3_last || lane_cnt == LANEW'(LANES - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lane_cnt <= '0;
            asm_q    <= '0;
        end else if (s3_valid) begin
            if (done_c) begin
                lane_cnt <= '0;
                asm_q    <= '0;
            end else begin
                lane_cnt <= lane_cnt + 1'b1;
                asm_q    <= word_c;
            end
        end
    end

    // ---------------- Output FIFO and flags
    logic            fifo_full, fifo_empty, pop, wr_ok;
    logic [CNTW-1:0] fifo_count, count_next;
    logic            almost_full_q, overflow_q;

    assign pop        = !fifo_empty && bus.i_ready;
    assign wr_ok      = done_c && (!fifo_full || pop);
    assign count_next = fifo_count + CNTW'(wr_ok) - CNTW'(pop);

    sync_fifo_fwft #(
        .DEPTH (FIFO_DEPTH_P),
        .WIDTH (WORDW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (done_c),
        .push_data (word_c),
        .pop       (pop),
        .pop_data  (bus.o_data),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            almost_full_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            almost_full_q <= (count_next >= AF_LEVEL);
            if (done_c && fifo_full && !pop) overflow_q <= 1'b1;
        end
    end

    assign bus.o_valid       = !fifo_empty;
    assign bus.o_almost_full = almost_full_q;
    assign bus.o_overflow    = overflow_q;

endmodule

// File: tb/tb_accum_requant_pack.sv
// Scoreboard bench: stimulus pushes model-predicted words, a monitor pops
// and compares each word the DUT hands over.
module tb_accum_requant_pack;
    import accum_requant_pack_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    accum_requant_pack_if bus ();

    accum_requant_pack dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int    checks   = 0;
    int    failures = 0;
    word_t exp_q[$];
    logic [7:0] m_elems[$];
    bit    gate_drops = 1'b0;
    word_t exp_w;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Reference requantization from plain 64-bit arithmetic.
    function automatic logic [7:0] ref_q(input longint d, input longint sc, input int sh,
                                         input longint zp, input bit relu);
        longint v;
        v = d * sc;
        if (sh > 0) v = (v + (longint'(1) << (sh - 1))) >>> sh;
        if (relu && v < 0) v = 0;
        v = v + zp;
        if (v > 127)  v = 127;
        if (v < -128) v = -128;
        return v[7:0];
    endfunction

    task automatic idle(input int n);
        bus.i_valid = 1'b0;
        bus.i_last  = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic signed [31:0] d, input logic [15:0] sc, input logic [5:0] sh,
                        input logic signed [7:0] zp, input logic relu, input logic last);
        word_t w;
        bus.i_valid      = 1'b1;
        bus.i_data       = d;
        bus.i_scale      = sc;
        bus.i_shift      = sh;
        bus.i_zero_point = zp;
        bus.i_relu       = relu;
        bus.i_last       = last;
        m_elems.push_back(ref_q(d, sc, int'(sh), zp, relu));
        if (last || m_elems.size() == LANES) begin
            w = '0;
            foreach (m_elems[k]) w[k*8 +: 8] = m_elems[k];
            m_elems.delete();
            if (!(gate_drops && exp_q.size() >= FIFO_DEPTH)) exp_q.push_back(w);
        end
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
        bus.i_last  = 1'b0;
    endtask

    task automatic drain(input string name);
        bus.i_ready = 1'b1;
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        check(name, 64'(exp_q.size()), 64'd0);
        idle(2);
        check({name, "_idle_valid"}, 64'(bus.o_valid), 64'd0);
    endtask

    // Monitor: every word leaving the FIFO must match the oldest prediction.
    always @(negedge clk) begin
        if (!rst && bus.o_valid && bus.i_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_word: got %h, expected no word", bus.o_data);
            end else begin
                exp_w = exp_q.pop_front();
                check("word", bus.o_data, exp_w);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic signed [31:0] d;
        rst = 1'b1;
        bus.i_valid = 1'b0; bus.i_data = '0; bus.i_last = 1'b0; bus.i_scale = '0;
        bus.i_shift = '0; bus.i_zero_point = '0; bus.i_relu = 1'b0; bus.i_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 64'(bus.o_valid), 64'd0);
        check("rst_data", bus.o_data, 64'd0);
        check("rst_afull", 64'(bus.o_almost_full), 64'd0);
        check("rst_ovf", 64'(bus.o_overflow), 64'd0);
        rst = 1'b0;
        idle(1);

        // Identity with latency measurement on the last element.
        for (int i = 1; i <= 7; i++) send(i, 16'd256, 6'd8, 8'sd0, 1'b0, 1'b0);
        send(8, 16'd256, 6'd8, 8'sd0, 1'b0, 1'b1);
        check("lat_n1", 64'(bus.o_valid), 64'd0);
        idle(1);
        check("lat_n2", 64'(bus.o_valid), 64'd0);
        idle(1);
        check("lat_n3", 64'(bus.o_valid), 64'd0);
        idle(1);
        check("lat_n4", 64'(bus.o_valid), 64'd1);
        drain("identity");

        // Saturation and rounding, one word per element.
        send(300,  16'd1, 6'd0, 8'sd0, 1'b0, 1'b1);
        send(-300, 16'd1, 6'd0, 8'sd0, 1'b0, 1'b1);
        send(3,    16'd1, 6'd1, 8'sd0, 1'b0, 1'b1);
        send(-3,   16'd1, 6'd1, 8'sd0, 1'b0, 1'b1);
        send(1,    16'd1, 6'd1, 8'sd0, 1'b0, 1'b1);
        // ReLU and zero point.
        send(-7, 16'd1, 6'd0, 8'sd5, 1'b1, 1'b1);
        send(10, 16'd1, 6'd0, 8'sd5, 1'b1, 1'b1);
        send(-7, 16'd1, 6'd0, 8'sd5, 1'b0, 1'b1);
        drain("satround_relu");

        // Partial flush followed by a full word starting at lane 0.
        for (int i = 1; i <= 3; i++) send(i, 16'd256, 6'd8, 8'sd0, 1'b0, i == 3);
        for (int i = 1; i <= 8; i++) send(i + 16, 16'd256, 6'd8, 8'sd0, 1'b0, i == 8);
        drain("partial");

        // Backpressure, almost-full threshold, push+pop at full, overflow.
        bus.i_ready = 1'b0;
        gate_drops  = 1'b1;
        for (int i = 1; i <= 3; i++) send(i, 16'd256, 6'd8, 8'sd0, 1'b0, 1'b1);
        idle(5);
        check("afull_at3", 64'(bus.o_almost_full), 64'd0);
        send(4, 16'd256, 6'd8, 8'sd0, 1'b0, 1'b1);
        idle(5);
        check("afull_at4", 64'(bus.o_almost_full), 64'd1);
        for (int i = 5; i <= 8; i++) send(i, 16'd256, 6'd8, 8'sd0, 1'b0, 1'b1);
        idle(5);
        check("full_no_ovf", 64'(bus.o_overflow), 64'd0);
        gate_drops = 1'b0;
        send(9, 16'd256, 6'd8, 8'sd0, 1'b0, 1'b1);
        idle(2);
        bus.i_ready = 1'b1;
        idle(1);
        bus.i_ready = 1'b0;
        idle(3);
        check("pushpop_full_ovf", 64'(bus.o_overflow), 64'd0);
        check("pushpop_full_afull", 64'(bus.o_almost_full), 64'd1);
        gate_drops = 1'b1;
        for (int i = 10; i <= 13; i++) send(i, 16'd256, 6'd8, 8'sd0, 1'b0, 1'b1);
        idle(5);
        check("ovf_set", 64'(bus.o_overflow), 64'd1);
        gate_drops = 1'b0;
        drain("backpressure");
        check("ovf_sticky", 64'(bus.o_overflow), 64'd1);

        // Reset with two buffered words and three elements in flight.
        bus.i_ready = 1'b0;
        send(21, 16'd256, 6'd8, 8'sd0, 1'b0, 1'b1);
        send(22, 16'd256, 6'd8, 8'sd0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) send(23 + i, 16'd256, 6'd8, 8'sd0, 1'b0, 1'b0);
        check("prerst_valid", 64'(bus.o_valid), 64'd1);
        rst = 1'b1;
        exp_q.delete();
        m_elems.delete();
        idle(1);
        check("midrst_valid", 64'(bus.o_valid), 64'd0);
        check("midrst_afull", 64'(bus.o_almost_full), 64'd0);
        check("midrst_ovf", 64'(bus.o_overflow), 64'd0);
        check("midrst_data", bus.o_data, 64'd0);
        rst = 1'b0;
        bus.i_ready = 1'b1;
        idle(10);
        check("postrst_no_stale", 64'(bus.o_valid), 64'd0);

        // Randomized traffic honouring the almost-full contract.
        for (int n = 0; n < 400; n++) begin
            bus.i_ready = ($urandom % 4) != 0;
            if (bus.o_almost_full || ($urandom % 5) == 0) begin
                idle(1);
            end else begin
                case ($urandom % 3)
                    0:       d = $urandom;
                    1:       d = $urandom_range(0, 2000) - 1000;
                    default: d = $urandom_range(0, 40) - 20;
                endcase
                send(d,
                     ($urandom % 2) ? 16'($urandom_range(0, 65535)) : 16'($urandom_range(0, 512)),
                     6'($urandom_range(0, 47)),
                     8'($urandom),
                     1'($urandom),
                     ($urandom % 6) == 0);
            end
        end
        // Flush any partial word so every prediction is retired.
        send(0, 16'd1, 6'd0, 8'sd0, 1'b0, 1'b1);
        drain("random");
        check("random_no_ovf", 64'(bus.o_overflow), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
